// File: rtl/sobel_window_gen.sv
// 3x3 Sobel neighbourhood generator: two line buffers plus 2-deep column shift registers, raster-order input.
// Window is registered on the accepting edge (valid the next cycle); a held window stalls pixel input until retired.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [PIX_W-1:0]              pix_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic [PIX_W-1:0]              win_p00_o,
  output logic [PIX_W-1:0]              win_p01_o,
  output logic [PIX_W-1:0]              win_p02_o,
  output logic [PIX_W-1:0]              win_p10_o,
  output logic [PIX_W-1:0]              win_p12_o,
  output logic [PIX_W-1:0]              win_p20_o,
  output logic [PIX_W-1:0]              win_p21_o,
  output logic [PIX_W-1:0]              win_p22_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o,
  output logic                          win_valid_o,
  input  logic                          win_ready_i,
  output logic                          busy_o,
  output logic                          frame_done_o
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  // Index 0 holds column c-2, index 1 column c-1; column c is the live read.
  logic [PIX_W-1:0] r_top [2];
  logic [PIX_W-1:0] r_mid [2];
  logic [PIX_W-1:0] r_bot [2];

  logic             r_busy;
  logic             r_win_valid;
  logic             r_frame_done;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_win_col;
  logic [RW-1:0]    r_win_row;
  logic [PIX_W-1:0] r_p00, r_p01, r_p02, r_p10, r_p12, r_p20, r_p21, r_p22;

  logic             w_accept;
  logic             w_emit;
  logic             w_last;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  assign pix_ready_o = r_busy && (!r_win_valid || win_ready_i);
  // start_i wins over a same-cycle pixel, so that pixel never touches any state.
  assign w_accept    = pix_valid_i && pix_ready_o && !start_i && !rst_i;
  assign w_emit      = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_last      = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= pix_i;
      r_top[0]     <= r_top[1];
      r_top[1]     <= w_lb1_rd;
      r_mid[0]     <= r_mid[1];
      r_mid[1]     <= w_lb0_rd;
      r_bot[0]     <= r_bot[1];
      r_bot[1]     <= pix_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy       <= 1'b0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_win_col    <= '0;
      r_win_row    <= '0;
      r_p00 <= '0; r_p01 <= '0; r_p02 <= '0; r_p10 <= '0;
      r_p12 <= '0; r_p20 <= '0; r_p21 <= '0; r_p22 <= '0;
    end else if (start_i) begin
      r_busy       <= 1'b1;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
    end else begin
      r_frame_done <= w_accept && w_last;
      if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row == ROW_LAST) begin
            r_row  <= '0;
            r_busy <= 1'b0;
          end else begin
            r_row <= r_row + ROW_ONE;
          end
        end else begin
          r_col <= r_col + COL_ONE;
        end
      end
      if (w_accept && w_emit) begin
        r_win_valid <= 1'b1;
        r_win_row   <= r_row - ROW_ONE;
        r_win_col   <= r_col - COL_ONE;
        r_p00 <= r_top[0]; r_p01 <= r_top[1]; r_p02 <= w_lb1_rd;
        r_p10 <= r_mid[0];                    r_p12 <= w_lb0_rd;
        r_p20 <= r_bot[0]; r_p21 <= r_bot[1]; r_p22 <= pix_i;
      end else if (win_ready_i) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_p00_o    = r_p00;
  assign win_p01_o    = r_p01;
  assign win_p02_o    = r_p02;
  assign win_p10_o    = r_p10;
  assign win_p12_o    = r_p12;
  assign win_p20_o    = r_p20;
  assign win_p21_o    = r_p21;
  assign win_p22_o    = r_p22;
  assign win_row_o    = r_win_row;
  assign win_col_o    = r_win_col;
  assign win_valid_o  = r_win_valid;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule
